// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: opcodes, FSM states, memory size codes, ALU op codes and the
// decoded control-field bundle shared by the multicycle controller.
package rv_ctrl_pkg;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   localparam logic [31:0] IR_NOP = 32'h0000_0013;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   localparam logic [1:0] MS_BYTE = 2'b00;
   localparam logic [1:0] MS_HALF = 2'b01;
   localparam logic [1:0] MS_WORD = 2'b10;

   localparam logic [1:0] MR_MEM  = 2'b00;
   localparam logic [1:0] MR_ALU  = 2'b01;
   localparam logic [1:0] MR_LUI  = 2'b10;
   localparam logic [1:0] MR_LINK = 2'b11;

   localparam logic [5:0] ALU_AND  = 6'b000000;
   localparam logic [5:0] ALU_OR   = 6'b000001;
   localparam logic [5:0] ALU_XOR  = 6'b000010;
   localparam logic [5:0] ALU_ADD  = 6'b000011;
   localparam logic [5:0] ALU_SLL  = 6'b001000;
   localparam logic [5:0] ALU_SRL  = 6'b001001;
   localparam logic [5:0] ALU_SRA  = 6'b001010;
   localparam logic [5:0] ALU_SUB  = 6'b010011;
   localparam logic [5:0] ALU_SLT  = 6'b010100;
   localparam logic [5:0] ALU_BGE  = 6'b010101;
   localparam logic [5:0] ALU_BEQ  = 6'b010110;
   localparam logic [5:0] ALU_BNE  = 6'b010111;
   localparam logic [5:0] ALU_SLTU = 6'b011011;
   localparam logic [5:0] ALU_BGEU = 6'b011100;

   typedef struct packed {
      logic [5:0] alu_op;
      logic       alu_in_sel;
      logic       branch;
      logic       jl;
      logic       jlr;
      logic       lui;
      logic       auipc;
      logic       is_load;
      logic       is_store;
      logic [1:0] memreg;
      logic [1:0] mem_size;
      logic       mem_unsigned;
      logic       illegal;
   } ctrl_t;

   function automatic logic [5:0] alu_f3(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  return alt ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return alt ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   // BLT/BLTU reuse the set-less-than ops; the ALU flag means "taken"
   function automatic logic [5:0] br_f3(input logic [2:0] f3);
      case (f3)
         3'b001:  return ALU_BNE;
         3'b100:  return ALU_SLT;
         3'b101:  return ALU_BGE;
         3'b110:  return ALU_SLTU;
         3'b111:  return ALU_BGEU;
         default: return ALU_BEQ;
      endcase
   endfunction
endpackage

// File: rtl/rv_decoder.sv
// rv_decoder: combinational RV32I decode of the instruction register into
// control fields plus an illegal flag.
module rv_decoder
   import rv_ctrl_pkg::*;
(
   input  logic [31:0] ir,
   output ctrl_t       ctrl
);
   logic [6:0] op, f7;
   logic [2:0] f3;
   logic       unused_bits;
   assign op = ir[6:0];
   assign f3 = ir[14:12];
   assign f7 = ir[31:25];
   assign unused_bits = ^{ir[24:15], ir[11:7]};
   always_comb begin
      ctrl = '0;
      ctrl.alu_op = ALU_ADD;
      ctrl.memreg = MR_ALU;
      ctrl.mem_size = f3[1:0];
      ctrl.mem_unsigned = f3[2];
      case (op)
         OP_LUI: begin
            ctrl.lui = 1'b1;
            ctrl.alu_in_sel = 1'b1;
            ctrl.memreg = MR_LUI;
         end
         OP_AUIPC: begin
            ctrl.auipc = 1'b1;
            ctrl.alu_in_sel = 1'b1;
         end
         OP_JAL: begin
            ctrl.jl = 1'b1;
            ctrl.alu_in_sel = 1'b1;
            ctrl.memreg = MR_LINK;
         end
         OP_JALR: begin
            ctrl.jlr = 1'b1;
            ctrl.alu_in_sel = 1'b1;
            ctrl.memreg = MR_LINK;
            ctrl.illegal = f3 != 3'b000;
         end
         OP_BRANCH: begin
            ctrl.branch = 1'b1;
            ctrl.alu_op = br_f3(f3);
            ctrl.illegal = f3[2:1] == 2'b01;
         end
         OP_LOAD: begin
            ctrl.is_load = 1'b1;
            ctrl.alu_in_sel = 1'b1;
            ctrl.memreg = MR_MEM;
            ctrl.illegal = f3[1:0] == 2'b11 || f3[2:1] == 2'b11;
         end
         OP_STORE: begin
            ctrl.is_store = 1'b1;
            ctrl.alu_in_sel = 1'b1;
            ctrl.illegal = f3[2] || f3[1:0] == 2'b11;
         end
         OP_IMM: begin
            ctrl.alu_in_sel = 1'b1;
            ctrl.alu_op = alu_f3(f3, f3 == 3'b101 && f7[5]);
            ctrl.illegal = f3 == 3'b001 ? f7 != 7'h00 :
                           f3 == 3'b101 ? f7 != 7'h00 && f7 != 7'h20 : 1'b0;
         end
         OP_REG: begin
            ctrl.alu_op = alu_f3(f3, f7[5]);
            ctrl.illegal = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
         end
         default: ctrl.illegal = 1'b1;
      endcase
   end
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FETCH/DECODE/EXEC/MEM/WB/TRAP sequencer with bus
// timeout, trap cause tracking and a retired-instruction counter.
module multicycle_control_unit
   import rv_ctrl_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter int BUS_TIMEOUT = 0,
   parameter int ALU_OP_W    = 6
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [31:0]         instr_rdata,
   output logic                i_req,
   input  logic                i_ack,
   output logic                d_req,
   output logic                d_we,
   input  logic                d_ack,
   output logic [1:0]          mem_size,
   output logic                mem_unsigned,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                alu_in_sel,
   output logic [1:0]          memreg,
   output logic                reg_we,
   output logic                pc_we,
   output logic                branch,
   output logic                jl,
   output logic                jlr,
   output logic                lui,
   output logic                auipc,
   output logic                illegal,
   output logic                bus_err,
   output logic [CNT_W-1:0]    instret,
   output logic [2:0]          state
);
   localparam int TW = BUS_TIMEOUT > 1 ? $clog2(BUS_TIMEOUT) : 1;
   state_t        cur, nxt;
   logic [31:0]   ir;
   logic [TW-1:0] tmo_cnt;
   logic          trap_bus, retire, waiting, timeout;
   ctrl_t         ctl;
   rv_decoder u_dec (.ir(ir), .ctrl(ctl));
   assign state = cur;
   assign waiting = (cur == S_FETCH && !i_ack) || (cur == S_MEM && !d_ack);
   assign timeout = BUS_TIMEOUT > 0 && waiting && 32'(tmo_cnt) == BUS_TIMEOUT - 1;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur      <= S_FETCH;
         ir       <= IR_NOP;
         instret  <= '0;
         tmo_cnt  <= '0;
         trap_bus <= 1'b0;
      end else begin
         cur      <= nxt;
         ir       <= (cur == S_FETCH && i_ack) ? instr_rdata : ir;
         instret  <= instret + CNT_W'(retire);
         tmo_cnt  <= (BUS_TIMEOUT > 0 && waiting && !timeout) ? tmo_cnt + 1'b1 : '0;
         trap_bus <= timeout;
      end
   end
   // i_req is gated by rst_n so the fetch request stays low while held in reset
   always_comb begin
      nxt = cur;
      i_req = 1'b0;
      d_req = 1'b0;
      d_we = 1'b0;
      mem_size = '0;
      mem_unsigned = 1'b0;
      alu_op = '0;
      alu_in_sel = 1'b0;
      memreg = '0;
      reg_we = 1'b0;
      pc_we = 1'b0;
      branch = 1'b0;
      jl = 1'b0;
      jlr = 1'b0;
      lui = 1'b0;
      auipc = 1'b0;
      illegal = 1'b0;
      bus_err = 1'b0;
      retire = 1'b0;
      case (cur)
         S_FETCH: begin
            i_req = rst_n;
            nxt = i_ack ? S_DECODE : timeout ? S_TRAP : S_FETCH;
         end
         S_DECODE: nxt = ctl.illegal ? S_TRAP : S_EXEC;
         S_EXEC: begin
            alu_op = ALU_OP_W'(ctl.alu_op);
            alu_in_sel = ctl.alu_in_sel;
            branch = ctl.branch;
            jl = ctl.jl;
            jlr = ctl.jlr;
            lui = ctl.lui;
            auipc = ctl.auipc;
            memreg = ctl.memreg;
            pc_we = ctl.branch;
            retire = ctl.branch;
            nxt = (ctl.is_load || ctl.is_store) ? S_MEM : ctl.branch ? S_FETCH : S_WB;
         end
         S_MEM: begin
            d_req = 1'b1;
            d_we = ctl.is_store;
            mem_size = ctl.mem_size;
            mem_unsigned = ctl.mem_unsigned;
            memreg = ctl.memreg;
            pc_we = d_ack && ctl.is_store;
            retire = d_ack && ctl.is_store;
            nxt = d_ack ? (ctl.is_store ? S_FETCH : S_WB) : timeout ? S_TRAP : S_MEM;
         end
         S_WB: begin
            reg_we = 1'b1;
            pc_we = 1'b1;
            retire = 1'b1;
            memreg = ctl.memreg;
            nxt = S_FETCH;
         end
         S_TRAP: begin
            pc_we = 1'b1;
            illegal = !trap_bus;
            bus_err = trap_bus;
            nxt = S_FETCH;
         end
         default: nxt = S_FETCH;
      endcase
   end
endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have parameter CNT_W, default 32, giving the retired-instruction counter width (range 8..64).
REQ-002 SHALL have parameter BUS_TIMEOUT, default 0, giving the maximum ack-wait cycles; 0 disables the timeout.
REQ-003 SHALL have parameter ALU_OP_W, default 6, giving the ALU opcode width.
REQ-004 SHALL have ports: clk input 1 clock; rst_n input 1 reset.
REQ-005 SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-006 SHALL have ports: instr_rdata input 32 fetched word; i_req output 1; i_ack input 1.
REQ-007 SHALL have ports: d_req output 1; d_we output 1; d_ack input 1; mem_size output 2 (00 byte, 01 half, 10 word); mem_unsigned output 1.
REQ-008 SHALL have ports: alu_op output ALU_OP_W; alu_in_sel output 1; memreg output 2.
REQ-009 SHALL have ports: reg_we, pc_we, branch, jl, jlr, lui, auipc, each output 1.
REQ-010 SHALL have ports: illegal output 1; bus_err output 1; instret output CNT_W; state output 3.

Function
REQ-011 SHALL implement the states FETCH, DECODE, EXEC, MEM, WB and TRAP.
REQ-012 FETCH SHALL hold i_req=1 until i_ack, latch instr_rdata into the IR, then go to DECODE; an ack in the first req cycle is legal.
REQ-013 DECODE SHALL take one cycle: go to TRAP if the opcode, funct3 or funct7 is illegal, otherwise go to EXEC.
REQ-014 Legal instructions SHALL be the RV32I R, I-imm, load, store, branch, JAL, JALR (funct3=000), LUI and AUIPC forms; SYSTEM and FENCE SHALL be illegal.
REQ-015 EXEC SHALL drive alu_op, alu_in_sel, branch, jl, jlr, lui and auipc from the IR.
REQ-016 EXEC SHALL go to MEM for loads and stores.
REQ-017 EXEC SHALL go to FETCH with pc_we=1 and instret+1 for branches.
REQ-018 EXEC SHALL go to WB for all other legal instructions.
REQ-019 MEM SHALL hold d_req=1 until d_ack, with d_we=1 for stores and mem_size/mem_unsigned from funct3.
REQ-020 On d_ack, MEM SHALL go to WB for loads, and to FETCH with pc_we=1 and instret+1 for stores.
REQ-021 WB SHALL assert reg_we=1 and pc_we=1 for exactly one cycle, increment instret, then go to FETCH.
REQ-022 TRAP SHALL pulse illegal (or bus_err) for one cycle with pc_we=1, leave instret unchanged, then go to FETCH.
REQ-023 memreg SHALL be 01 for ALU/AUIPC, 00 for loads, 10 for LUI and 11 for JAL/JALR, and SHALL be valid in EXEC, MEM and WB.
REQ-024 alu_op SHALL be ADD for addresses, loads, stores, JALR and LUI.
REQ-025 alu_op for ANDI SHALL be AND.
REQ-026 SRLI and SRAI SHALL decode from funct3=101 with funct7 0000000 or 0100000 respectively.
REQ-027 When BUS_TIMEOUT>0, a req held for BUS_TIMEOUT cycles without ack SHALL abort to TRAP with bus_err.
REQ-028 An ack with no outstanding req SHALL be ignored.
REQ-029 instret SHALL wrap modulo 2^CNT_W.
REQ-030 Outside their defined states, all control outputs SHALL be 0.

Reset
REQ-031 While rst_n=0, the state SHALL be FETCH (with i_req held 0 until release), IR=0x00000013, instret=0, the timeout counter=0, and all other outputs 0; this SHALL take effect asynchronously, including mid-MEM or mid-FETCH.
REQ-032 The first i_req SHALL assert in the first clock cycle after rst_n deasserts.

Structure
REQ-033 Package rv_ctrl_pkg SHALL hold the opcode localparams, state encodings, mem_size codes and ALU_op codes.
REQ-034 The ALU_op codes SHALL be AND 000000, OR 000001, XOR 000010, ADD 000011, SLL 001000, SRL 001001, SRA 001010, SUB 010011, SLT 010100, BGE 010101, BEQ 010110, BNE 010111, SLTU 011011 and BGEU 011100.
REQ-035 A combinational sub-module rv_decoder SHALL map the IR to control fields plus illegal; the FSM, timeout counter and instret SHALL live in the top.

Verification
REQ-036 ADD 0x002081B3 with zero-wait i_ack -> FETCH, DECODE, EXEC, WB in 4 cycles; alu_op=000011; reg_we high 1 cycle; instret 0 to 1.
REQ-037 LW 0x0000A103 with d_ack 3 cycles late -> d_req high 4 cycles; mem_size=10; memreg=00; reg_we in WB.
REQ-038 BEQ 0x00208463 -> alu_op=010110; branch=1 in EXEC; pc_we=1; no reg_we; instret+1.
REQ-039 0xFFFFFFFF, then ECALL 0x00000073 -> illegal pulses twice; instret unchanged.
REQ-040 BUS_TIMEOUT=4 with i_ack never asserted -> bus_err at the 4th req cycle, then FETCH retries.
REQ-041 rst_n pulled low mid-MEM of SW 0x0020A023 -> d_req and d_we drop without a clock edge; instret=0.
